// File: rtl/lsu.sv
// Load/store unit: turns one RV32 load/store request into a single handshaked
// SRAM access. Handles lane selection, store-data replication, load
// extension and misalignment/illegal-code faults.
module lsu #(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [DADDR-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [DADDR-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [DADDR-1:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               fault_q;
  logic [WIDTH-1:0]   rdata_q;
  logic               req_ok;
  logic [3:0]         be;
  logic [WIDTH-1:0]   wdata_lane;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [WIDTH-1:0]   load_ext;

  // Decide whether the incoming request is a legal, aligned access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_ok = 1'b0;
    case (req_funct3)
      3'd0:    req_ok = 1'b1;
      3'd1:    req_ok = ~req_addr[0];
      3'd2:    req_ok = (req_addr[1:0] == 2'b00);
      3'd4:    req_ok = ~req_we;                 // BU has no store form
      3'd5:    req_ok = ~req_we & ~req_addr[0];  // HU has no store form
      default: req_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = req_ok ? S_REQ : S_DONE;
      S_REQ:  if (mem_gnt) state_nxt = we_q ? S_DONE : S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the request on accept and capture the extended load result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        fault_q  <= ~req_ok;
      end
      if (state == S_WAIT && mem_rvalid) begin
        rdata_q <= load_ext;
      end
    end
  end

  // Byte enables and lane-replicated store data from the latched request.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_q[1:0];
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00: lane_b = mem_rdata[7:0];
      2'b01: lane_b = mem_rdata[15:8];
      2'b10: lane_b = mem_rdata[23:16];
      2'b11: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_ext = {24'd0, lane_b};
      3'd5:    load_ext = {16'd0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Outputs decoded from state and the latched request only.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_req   = (state == S_REQ);
    mem_we    = mem_req & we_q;
    mem_be    = mem_req ? be : 4'b0000;
    mem_addr  = mem_req ? {addr_q[DADDR-1:2], 2'b00} : '0;
    mem_wdata = (mem_req & we_q) ? wdata_lane : '0;
    fault     = fault_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected completions into a
// scoreboard; a monitor pops and compares on every done pulse.
module tb_lsu;

  localparam int WIDTH = 32;
  localparam int DADDR = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid = 1'b0;
  logic             req_we = 1'b0;
  logic [2:0]       req_funct3 = 3'd0;
  logic [DADDR-1:0] req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             busy, done, fault;
  logic [WIDTH-1:0] rdata;
  logic             mem_req, mem_we;
  logic [3:0]       mem_be;
  logic [DADDR-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_gnt = 1'b0;
  logic             mem_rvalid = 1'b0;
  logic [WIDTH-1:0] mem_rdata = '0;

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          req_cycles = 0;
  logic [31:0] model_rdata = 32'd0;

  lsu #(.WIDTH(WIDTH), .DADDR(DADDR)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles in which a memory request is presented.
  always @(negedge clk) if (mem_req === 1'b1) req_cycles++;

  // Monitor: every done pulse is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_fault", {31'd0, fault}, {31'd0, e.fault});
        check("done_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic check_bus(input string tag, input logic we, input logic [9:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    check({tag, "_mem_req"},   {31'd0, mem_req}, 32'd1);
    check({tag, "_mem_we"},    {31'd0, mem_we}, {31'd0, we});
    check({tag, "_mem_be"},    {28'd0, mem_be}, {28'd0, be});
    check({tag, "_mem_addr"},  {22'd0, mem_addr}, {22'd0, addr[9:2], 2'b00});
    check({tag, "_mem_wdata"}, mem_wdata, wd);
  endtask

  // One complete access; call at posedge+1 with the DUT idle.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] word,
                        input logic exp_fault, input logic [31:0] exp_load,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int   base;
    exp_t e;
    e.fault = exp_fault;
    e.rdata = (exp_fault || we) ? model_rdata : exp_load;
    model_rdata = e.rdata;
    sb.push_back(e);
    base = req_cycles;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    if (!exp_fault) begin
      for (int i = 0; i < gnt_dly; i++) begin
        @(negedge clk);
        check_bus(tag, we, addr, exp_be, exp_wd);
        tick();
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      check_bus(tag, we, addr, exp_be, exp_wd);
      tick();
      mem_gnt = 1'b0;
      if (!we) begin
        for (int i = 0; i < rv_dly; i++) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_done_cycle"}, {31'd0, done}, 32'd1);
    tick();
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_req_cycles"}, req_cycles - base, exp_fault ? 32'd0 : gnt_dly + 1);
    tick();
  endtask

  initial begin
    int base;
    exp_t e;

    // Reset values, asserted asynchronously.
    reset_n = 1'b0;
    #1;
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    check("rst_fault",     {31'd0, fault}, 32'd0);
    check("rst_rdata",     rdata, 32'd0);
    check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst_mem_be",    {28'd0, mem_be}, 32'd0);
    check("rst_mem_addr",  {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset while waiting for read data; the late rvalid must be dropped.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 10'h008;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("wait_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_mem_req", {31'd0, mem_req}, 32'd0);
    check("arst_busy",    {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("arst_rdata", rdata, 32'd0);
    check("arst_busy2", {31'd0, busy}, 32'd0);
    tick();

    // SB with two grant wait states.
    access("sb", 1'b1, 3'd0, 10'h006, 32'h000000A5, 2, 0, 32'd0,
           1'b0, 32'd0, 4'b0100, 32'hA5A5A5A5);
    // Byte loads from the top lane.
    access("lb", 1'b0, 3'd0, 10'h003, 32'd0, 0, 0, 32'h80FF7F01,
           1'b0, 32'hFFFFFF80, 4'b1000, 32'd0);
    access("lbu", 1'b0, 3'd4, 10'h003, 32'd0, 1, 2, 32'h80FF7F01,
           1'b0, 32'h00000080, 4'b1000, 32'd0);
    // Halfword and word loads.
    access("lh", 1'b0, 3'd1, 10'h002, 32'd0, 0, 1, 32'h8001FFFF,
           1'b0, 32'hFFFF8001, 4'b1100, 32'd0);
    access("lhu", 1'b0, 3'd5, 10'h002, 32'd0, 0, 0, 32'h8001FFFF,
           1'b0, 32'h00008001, 4'b1100, 32'd0);
    access("lw", 1'b0, 3'd2, 10'h000, 32'd0, 0, 0, 32'h8001FFFF,
           1'b0, 32'h8001FFFF, 4'b1111, 32'd0);
    // SH to the lower half.
    access("sh", 1'b1, 3'd1, 10'h010, 32'h1234BEEF, 0, 0, 32'd0,
           1'b0, 32'd0, 4'b0011, 32'hBEEFBEEF);
    // Faults: no memory access, rdata untouched.
    access("lw_mis", 1'b0, 3'd2, 10'h001, 32'd0, 0, 0, 32'd0,
           1'b1, 32'd0, 4'b0000, 32'd0);
    access("sh_mis", 1'b1, 3'd1, 10'h003, 32'h0000FFFF, 0, 0, 32'd0,
           1'b1, 32'd0, 4'b0000, 32'd0);
    access("f3_ill", 1'b0, 3'd3, 10'h000, 32'd0, 0, 0, 32'd0,
           1'b1, 32'd0, 4'b0000, 32'd0);
    access("sbu_ill", 1'b1, 3'd4, 10'h000, 32'd0, 0, 0, 32'd0,
           1'b1, 32'd0, 4'b0000, 32'd0);
    // Non-fault done after a fault clears fault.
    access("sw", 1'b1, 3'd2, 10'h020, 32'h0BADF00D, 0, 0, 32'd0,
           1'b0, 32'd0, 4'b1111, 32'h0BADF00D);

    // req_valid held high across a whole load: one request, next accept in cycle 6.
    e.fault = 1'b0; e.rdata = 32'h12345678; sb.push_back(e);
    e.fault = 1'b0; e.rdata = 32'hCAFEF00D; sb.push_back(e);
    base = req_cycles;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 10'h010;
    tick();                                   // cycle 1: REQ
    mem_gnt = 1'b1;
    tick();                                   // cycle 2: WAIT
    mem_gnt = 1'b0;
    tick();                                   // cycle 3
    tick();                                   // cycle 4
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();                                   // cycle 5: DONE
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("hold_done_c5", {31'd0, done}, 32'd1);
    tick();                                   // cycle 6: IDLE, accepts
    req_addr = 10'h014;
    @(negedge clk);
    check("hold_idle_c6", {31'd0, busy}, 32'd0);
    check("hold_one_req", req_cycles - base, 32'd1);
    tick();                                   // cycle 7: REQ again
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    check("hold_req_c7", {31'd0, mem_req}, 32'd1);
    check("hold_addr_c7", {22'd0, mem_addr}, 32'h014);
    tick();                                   // cycle 8: WAIT
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();                                   // cycle 9: DONE
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("hold2_done", {31'd0, done}, 32'd1);
    tick();
    repeat (3) tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got 0x00000001 expected 0x00000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the single-cycle datapath's data-memory port and a synchronous, handshaked data SRAM. Accepts one load or store per request (RV32 funct3 encoding). Generates word-aligned addresses and byte enables, replicates store data across lanes, and sign/zero-extends load data. Flags misaligned or illegal accesses without touching memory, and reports completion with a one-cycle pulse so the controller can stall the PC meanwhile.

## Interface
- WIDTH, 32, data width; lane logic requires exactly 32
- DADDR, 10, byte-address width of the data memory
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  start request; sampled only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU)
- req_addr  in  DADDR  byte address
- req_wdata  in  WIDTH  store data (low bytes used for B/H)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1 = misaligned/illegal, no memory access made
- rdata  out  WIDTH  extended load result; held until next load completes
- mem_req  out  1  memory request, high only in REQ
- mem_we  out  1  memory write strobe
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_addr  out  DADDR  word address, bits [1:0] forced 0
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  mem_rdata valid this cycle
- mem_rdata  in  WIDTH  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On req_valid, latch we/funct3/addr/wdata.
  - Legal and aligned -> REQ.
  - Otherwise -> DONE with fault=1.
- Legality:
  - funct3 in {3,6,7} is illegal.
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - Illegal stores with funct3 4/5 are also faults.
- REQ:
  - mem_req=1; mem_we/be/addr/wdata come from the latched request and stay stable until grant.
  - On mem_gnt: store -> DONE, load -> WAIT.
- WAIT: on mem_rvalid, register the extended result into rdata, then -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Byte enables and store data:
  - B: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - W: be = 1111, wdata as-is.
  - Loads drive the same be; mem_we=0.
- Load extension:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- rdata updates only on load completion; stores and faults leave it unchanged.
- fault is cleared at every non-fault done.
- Ignored inputs:
  - req_valid while busy.
  - mem_gnt outside REQ.
  - mem_rvalid outside WAIT, including the cycle of the grant.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, fault=0, rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset mid-transaction abandons the access. mem_req drops asynchronously. A granted-but-unreturned read is discarded.
- Accept in cycle 0 (IDLE): REQ in cycle 1, busy=1 from cycle 1.
- Store with gnt in cycle 1: done in cycle 2; minimum store latency is 2 cycles from accept.
- Load with gnt in cycle 1 and rvalid in cycle 2: done in cycle 3, rdata valid in that cycle; minimum load latency is 3 cycles.
- Each gnt wait state and each rvalid wait state adds one cycle.
- Fault accepted in cycle 0: done=1, fault=1 in cycle 1; mem_req never asserts.
- After done, the earliest next accept is the following cycle (IDLE); back-to-back store throughput is one request per 3 cycles.
- All outputs are registered or decoded from state plus latched request only; no combinational path from req_* to mem_*.

## Test plan
- Reset during WAIT with rvalid arriving next cycle -> mem_req=0 and busy=0 immediately; rvalid ignored; rdata stays 0.
- SB addr=0x006, wdata=0x000000A5, gnt held low 2 cycles -> mem_req high 3 cycles with mem_addr=0x004, be=0100, mem_wdata=0xA5A5A5A5 stable; done 1 cycle after gnt; rdata unchanged.
- LB addr=0x003, mem_rdata=0x80FF7F01 -> rdata=0xFFFFFF80; repeat with LBU -> 0x00000080.
- LH addr=0x002, mem_rdata=0x8001FFFF -> rdata=0xFFFF8001; LHU -> 0x00008001; LW addr=0x000 -> 0x8001FFFF.
- LW addr=0x001, SH addr=0x003, funct3=3 -> each gives done+fault one cycle after accept; mem_req never asserts.
- req_valid held high throughout a load, gnt immediate, rvalid after 3 cycles -> exactly one memory request; done at cycle 5; next request accepted only at cycle 6.
